rgb_video_rx: RTL and testbench

- Receive-side counterpart of the LCD RGB timing generator: samples a parallel RGB888 video interface (de/hs/vs/rgb) and recovers a pixel stream with x/y coordinates and frame/line markers.
- Measures the active resolution and reports format lock, so the image-processing chain (e.g. Sobel) can take camera or loop-back video in the same format the LCD driver emits.
- Sits between the video input pins and the processing pipeline, in the pixel clock domain.

---
 rtl/rgb_video_rx.sv | 267 ++++++++++++++++++++++++++
 tb/tb_rgb_video_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_video_rx.sv
// Parallel RGB888 video receiver: recovers pixel stream with x/y, frame/line markers,
// measures active resolution and tracks format lock. Optional macro RX_GRAY_EN adds luma output stage.
module rgb_video_rx #(
   parameter bit          HS_POL      = 1'b0,
   parameter bit          VS_POL      = 1'b0,
   parameter int unsigned LOCK_FRAMES = 2,
   parameter int unsigned MAX_DIM     = 2047
) (
   input  logic        lcd_pclk,
   input  logic        rst_n,
   input  logic        vid_de,
   input  logic        vid_hs,
   input  logic        vid_vs,
   input  logic [23:0] vid_rgb,
   output logic        pix_valid,
   output logic [23:0] pix_data,
   output logic [10:0] pix_xpos,
   output logic [10:0] pix_ypos,
   output logic        frame_start,
   output logic        line_end,
   output logic [10:0] h_act,
   output logic [10:0] v_act,
   output logic        fmt_locked,
   output logic        fmt_err
);

   localparam int unsigned DW = 11;
   localparam int unsigned CW = 4;
   localparam logic [DW-1:0] DMAX   = DW'(MAX_DIM);
   localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);

   typedef enum logic [1:0] {ST_UNLOCK, ST_CHECK, ST_LOCKED} state_t;

   function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
      return (v >= DMAX) ? v : v + DW'(1);
   endfunction

   // input register stage, sync polarity normalised to active-high
   logic          de_a, hs_a, vs_a;
   logic [23:0]   rgb_a;
   // previous sample (edge reference) and pixel under output
   logic          de_b, vs_b, pv_b, fs_b;
   logic [23:0]   rgb_b;
   logic [DW-1:0] x_b, y_b;
   // frame measurement state
   logic          armed, fs_pend, line_mis, sat_flag;
   logic [DW-1:0] x_cnt, y_cnt, cur_w;
   // lock tracker
   state_t        state_q, state_d;
   logic [DW-1:0] ref_w_q, ref_w_d, ref_h_q, ref_h_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_c;

   logic          vs_edge_c, line_close_c, first_line_c, wid_mis_c;
   logic          f_mis_c, f_sat_c, frame_end_c, pv_c, fs_c, le_c, match_c;
   logic [DW-1:0] x_pix_c, y_pix_c, f_w_c, f_h_c;

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         de_a  <= 1'b0;
         hs_a  <= 1'b0;
         vs_a  <= 1'b0;
         rgb_a <= '0;
      end else begin
         de_a  <= vid_de;
         hs_a  <= (vid_hs == HS_POL);
         vs_a  <= (vid_vs == VS_POL);
         rgb_a <= vid_rgb;
      end
   end

   // a line closes before the frame when de falls on the vs edge
   always_comb begin
      vs_edge_c    = vs_a & ~vs_b;
      line_close_c = armed & de_b & (~de_a | vs_edge_c);
      first_line_c = (y_cnt == '0);
      wid_mis_c    = line_close_c & ~first_line_c & (x_cnt != cur_w);
      x_pix_c      = (vs_edge_c | ~de_b) ? '0 : x_cnt;
      y_pix_c      = vs_edge_c ? '0 : y_cnt;
      f_w_c        = (line_close_c & first_line_c) ? x_cnt : cur_w;
      f_h_c        = line_close_c ? sat_inc(y_cnt) : y_cnt;
      f_mis_c      = line_mis | wid_mis_c;
      f_sat_c      = sat_flag | (line_close_c & (y_cnt == DMAX));
      frame_end_c  = vs_edge_c & armed & (f_h_c != '0);
      pv_c         = de_a & (armed | vs_edge_c);
      fs_c         = pv_c & (fs_pend | vs_edge_c);
      le_c         = pv_b & (~de_a | vs_edge_c);
      match_c      = (f_w_c == ref_w_q) && (f_h_c == ref_h_q);
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         de_b     <= 1'b0;
         vs_b     <= 1'b0;
         pv_b     <= 1'b0;
         fs_b     <= 1'b0;
         rgb_b    <= '0;
         x_b      <= '0;
         y_b      <= '0;
         armed    <= 1'b0;
         fs_pend  <= 1'b0;
         line_mis <= 1'b0;
         sat_flag <= 1'b0;
         x_cnt    <= '0;
         y_cnt    <= '0;
         cur_w    <= '0;
      end else begin
         de_b  <= de_a;
         vs_b  <= vs_a;
         pv_b  <= pv_c;
         fs_b  <= fs_c;
         rgb_b <= rgb_a;
         x_b   <= x_pix_c;
         y_b   <= y_pix_c;
         x_cnt <= de_a ? sat_inc(x_pix_c) : '0;
         if (pv_c)
            fs_pend <= 1'b0;
         else if (vs_edge_c)
            fs_pend <= 1'b1;
         if (vs_edge_c) begin
            armed    <= 1'b1;
            y_cnt    <= '0;
            cur_w    <= '0;
            line_mis <= 1'b0;
            sat_flag <= 1'b0;
         end else begin
            if (line_close_c) begin
               y_cnt <= sat_inc(y_cnt);
               if (first_line_c)
                  cur_w <= x_cnt;
            end
            if (wid_mis_c || (armed && de_a && hs_a))
               line_mis <= 1'b1;
            if ((line_close_c && (y_cnt == DMAX)) || (pv_c && (x_pix_c == DMAX)))
               sat_flag <= 1'b1;
         end
      end
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_UNLOCK;
         ref_w_q <= '0;
         ref_h_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ref_w_q <= ref_w_d;
         ref_h_q <= ref_h_d;
         cnt_q   <= cnt_d;
      end
   end

   // lock tracker, evaluated once per non-empty frame
   always_comb begin
      state_d = state_q;
      ref_w_d = ref_w_q;
      ref_h_d = ref_h_q;
      cnt_d   = cnt_q;
      err_c   = 1'b0;
      if (frame_end_c) begin
         case (state_q)
            ST_UNLOCK: begin
               ref_w_d = f_w_c;
               ref_h_d = f_h_c;
               cnt_d   = CW'(1);
               state_d = (LOCK_N <= CW'(1)) ? ST_LOCKED : ST_CHECK;
            end
            ST_CHECK: begin
               if (match_c && !f_mis_c) begin
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_d >= LOCK_N)
                     state_d = ST_LOCKED;
               end else begin
                  ref_w_d = f_w_c;
                  ref_h_d = f_h_c;
                  cnt_d   = CW'(1);
               end
            end
            ST_LOCKED: begin
               if (!match_c || f_mis_c || f_sat_c) begin
                  err_c   = 1'b1;
                  state_d = ST_UNLOCK;
               end
            end
            default: state_d = ST_UNLOCK;
         endcase
      end
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         h_act      <= '0;
         v_act      <= '0;
         fmt_locked <= 1'b0;
         fmt_err    <= 1'b0;
      end else begin
         fmt_locked <= (state_d == ST_LOCKED);
         fmt_err    <= err_c;
         if (frame_end_c) begin
            h_act <= f_w_c;
            v_act <= f_h_c;
         end
      end
   end

`ifdef RX_GRAY_EN
   logic          g_valid, g_fs, g_le;
   logic [23:0]   g_rgb;
   logic [DW-1:0] g_x, g_y;
   logic [15:0]   luma_c;

   // full-scale white sums to 65280, so 16 bits never overflow
   always_comb begin
      luma_c = 16'd77 * 16'(g_rgb[23:16]) + 16'd150 * 16'(g_rgb[15:8]) + 16'd29 * 16'(g_rgb[7:0]);
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         g_valid     <= 1'b0;
         g_fs        <= 1'b0;
         g_le        <= 1'b0;
         g_rgb       <= '0;
         g_x         <= '0;
         g_y         <= '0;
         pix_valid   <= 1'b0;
         pix_data    <= '0;
         pix_xpos    <= '0;
         pix_ypos    <= '0;
         frame_start <= 1'b0;
         line_end    <= 1'b0;
      end else begin
         g_valid     <= pv_b;
         g_fs        <= fs_b;
         g_le        <= le_c;
         g_rgb       <= pv_b ? rgb_b : '0;
         g_x         <= pv_b ? x_b : '0;
         g_y         <= pv_b ? y_b : '0;
         pix_valid   <= g_valid;
         pix_data    <= g_valid ? {3{luma_c[15:8]}} : '0;
         pix_xpos    <= g_x;
         pix_ypos    <= g_y;
         frame_start <= g_fs;
         line_end    <= g_le;
      end
   end
`else
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         pix_valid   <= 1'b0;
         pix_data    <= '0;
         pix_xpos    <= '0;
         pix_ypos    <= '0;
         frame_start <= 1'b0;
         line_end    <= 1'b0;
      end else begin
         pix_valid   <= pv_b;
         pix_data    <= pv_b ? rgb_b : '0;
         pix_xpos    <= pv_b ? x_b : '0;
         pix_ypos    <= pv_b ? y_b : '0;
         frame_start <= fs_b;
         line_end    <= le_c;
      end
   end
`endif

endmodule

// File: tb/tb_rgb_video_rx.sv
// Testbench for rgb_video_rx: random pixel content over directed frame geometries,
// checked cycle by cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_rgb_video_rx;

   localparam bit HS_POL      = 1'b0;
   localparam bit VS_POL      = 1'b0;
   localparam int LOCK_FRAMES = 2;
   localparam int MAXD        = 2047;
`ifdef RX_GRAY_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vid_de, vid_hs, vid_vs;
   logic [23:0] vid_rgb;
   logic        pix_valid, frame_start, line_end, fmt_locked, fmt_err;
   logic [23:0] pix_data;
   logic [10:0] pix_xpos, pix_ypos, h_act, v_act;

   always #5 clk = ~clk;

   rgb_video_rx #(.HS_POL(HS_POL), .VS_POL(VS_POL), .LOCK_FRAMES(LOCK_FRAMES), .MAX_DIM(MAXD)) dut (
      .lcd_pclk(clk), .rst_n(rst_n), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
      .vid_rgb(vid_rgb), .pix_valid(pix_valid), .pix_data(pix_data), .pix_xpos(pix_xpos),
      .pix_ypos(pix_ypos), .frame_start(frame_start), .line_end(line_end), .h_act(h_act),
      .v_act(v_act), .fmt_locked(fmt_locked), .fmt_err(fmt_err)
   );

   typedef struct packed {
      logic v; logic [23:0] d; logic [10:0] x; logic [10:0] y; logic fs; logic le;
   } pexp_t;
   typedef struct packed {
      logic [10:0] h; logic [10:0] v; logic lk; logic err;
   } sexp_t;

   pexp_t pq[$];
   sexp_t sq[$];
   int    n_assert = 0;
   int    n_fail   = 0;

   // reference model state
   bit m_armed, m_de, m_vs, m_fs_pend, m_hs_bad;
   int m_run;
   int widths[$];
   bit m_lk, m_chk, m_err;
   int m_rw, m_rh, m_cnt, m_h, m_v;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] ref_pix(input logic [23:0] p);
`ifdef RX_GRAY_EN
      int r, g, b, y;
      r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
      y = (77 * r + 150 * g + 29 * b) / 256;
      return {3{8'(y)}};
`else
      return p;
`endif
   endfunction

   function automatic int clip(input int v);
      return (v > MAXD) ? MAXD : v;
   endfunction

   task automatic model_reset();
      m_armed = 0; m_de = 0; m_vs = 0; m_fs_pend = 0; m_hs_bad = 0; m_run = 0;
      widths.delete();
      m_lk = 0; m_chk = 0; m_err = 0; m_rw = 0; m_rh = 0; m_cnt = 0; m_h = 0; m_v = 0;
      pq.delete(); sq.delete();
      repeat (LAT + 1) pq.push_back('0);
      repeat (2) sq.push_back('0);
   endtask

   // lock rules applied to a completed frame
   task automatic frame_eval();
      int w, h;
      bit mis, sat, match;
      w = clip(widths[0]);
      h = clip(widths.size());
      mis = m_hs_bad;
      sat = 0;
      foreach (widths[i]) begin
         if (clip(widths[i]) != w) mis = 1;
         if (widths[i] > MAXD) sat = 1;
      end
      m_h = w; m_v = h;
      match = (w == m_rw) && (h == m_rh);
      if (m_lk) begin
         if (!match || mis || sat) begin m_err = 1; m_lk = 0; m_chk = 0; end
      end else if (m_chk && match && !mis) begin
         m_cnt++;
         if (m_cnt >= LOCK_FRAMES) begin m_lk = 1; m_chk = 0; end
      end else begin
         m_rw = w; m_rh = h; m_cnt = 1;
         if (LOCK_FRAMES <= 1) m_lk = 1; else m_chk = 1;
      end
   endtask

   task automatic check_all_zero(input string where);
      chk({where, ".pix_valid"}, 32'(pix_valid), 0);
      chk({where, ".pix_data"}, 32'(pix_data), 0);
      chk({where, ".pix_xpos"}, 32'(pix_xpos), 0);
      chk({where, ".pix_ypos"}, 32'(pix_ypos), 0);
      chk({where, ".frame_start"}, 32'(frame_start), 0);
      chk({where, ".line_end"}, 32'(line_end), 0);
      chk({where, ".h_act"}, 32'(h_act), 0);
      chk({where, ".v_act"}, 32'(v_act), 0);
      chk({where, ".fmt_locked"}, 32'(fmt_locked), 0);
      chk({where, ".fmt_err"}, 32'(fmt_err), 0);
   endtask

   // one pixel clock: compare delayed expectations, drive inputs, advance model
   task automatic step(input bit de, input bit hs_act, input bit vs_act, input logic [23:0] rgb, input bit last);
      pexp_t e;
      sexp_t s;
      bit    edge_v;
      int    x;
      @(negedge clk);
      if (pq.size() == LAT + 1) begin
         e = pq.pop_front();
         chk("pix_valid", 32'(pix_valid), 32'(e.v));
         if (e.v) begin
            chk("pix_data", 32'(pix_data), 32'(e.d));
            chk("pix_xpos", 32'(pix_xpos), 32'(e.x));
            chk("pix_ypos", 32'(pix_ypos), 32'(e.y));
         end
         chk("frame_start", 32'(frame_start), 32'(e.fs));
         chk("line_end", 32'(line_end), 32'(e.le));
      end
      if (sq.size() == 2) begin
         s = sq.pop_front();
         chk("h_act", 32'(h_act), 32'(s.h));
         chk("v_act", 32'(v_act), 32'(s.v));
         chk("fmt_locked", 32'(fmt_locked), 32'(s.lk));
         chk("fmt_err", 32'(fmt_err), 32'(s.err));
      end
      vid_de  = de;
      vid_hs  = hs_act ? HS_POL : ~HS_POL;
      vid_vs  = vs_act ? VS_POL : ~VS_POL;
      vid_rgb = rgb;

      m_err  = 0;
      edge_v = vs_act && !m_vs;
      if (m_armed && m_de && (!de || edge_v)) widths.push_back(m_run);
      if (edge_v) begin
         if (m_armed && widths.size() > 0) frame_eval();
         widths.delete();
         m_hs_bad = 0; m_armed = 1; m_fs_pend = 1;
      end
      e = '0;
      if (de) begin
         if (!m_de || edge_v) m_run = 0;
         x = m_run;
         m_run++;
         if (m_armed) begin
            if (hs_act && !edge_v) m_hs_bad = 1;
            e.v  = 1;
            e.d  = ref_pix(rgb);
            e.x  = 11'(clip(x));
            e.y  = 11'(clip(widths.size()));
            e.fs = m_fs_pend;
            e.le = last;
            m_fs_pend = 0;
         end
      end
      m_de = de;
      m_vs = vs_act;
      pq.push_back(e);
      sq.push_back({11'(m_h), 11'(m_v), m_lk, m_err});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   // vs pulse, then h lines; optional short line gl of width gw; optional reset at x = rx of line 0
   task automatic drive_frame(input int w, input int h, input int gl, input int gw, input int rx);
      int lw;
      logic [23:0] px;
      repeat (4) step(0, 0, 1, '0, 0);
      repeat (2) step(0, 0, 0, '0, 0);
      for (int l = 0; l < h; l++) begin
         lw = (l == gl) ? gw : w;
         repeat (2) step(0, 1, 0, '0, 0);
         repeat (2) step(0, 0, 0, '0, 0);
         for (int x = 0; x < lw; x++) begin
            px = (x == 0) ? 24'hFF0000 : (x == 1) ? 24'hFFFFFF : 24'($urandom);
            step(1, 0, 0, px, x == lw - 1);
            if (l == 0 && x == rx) do_reset();
         end
         repeat (2) step(0, 0, 0, '0, 0);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      vid_de  = 1'b0;
      vid_hs  = ~HS_POL;
      vid_vs  = ~VS_POL;
      vid_rgb = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      model_reset();
      rst_n = 1'b1;
      repeat (5) step(0, 0, 0, '0, 0);

      repeat (4) drive_frame(16, 6, -1, 0, -1);
      repeat (4) drive_frame(24, 8, -1, 0, -1);
      repeat (3) drive_frame(16, 6, -1, 0, -1);
      drive_frame(16, 6, 3, 15, -1);
      repeat (3) drive_frame(16, 6, -1, 0, -1);
      drive_frame(2100, 2, -1, 0, -1);
      drive_frame(240, 2, -1, 0, 200);
      repeat (3) drive_frame(16, 6, -1, 0, -1);
      repeat (4) step(0, 0, 1, '0, 0);
      repeat (LAT + 6) step(0, 0, 0, '0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
